// File: rtl/counter_loop_nest_if.sv
// Handshake and index bus between the loop-nest counter and its controller.
// The controller drives start/abort/en, mode and limits; the counter returns indices and status.
interface counter_loop_nest_if #(
   parameter int INNER_W = 6,
   parameter int OUTER_W = 6
);
   logic               start;
   logic               abort;
   logic               en;
   logic               cont_mode;
   logic [INNER_W-1:0] inner_limit;
   logic [OUTER_W-1:0] outer_limit;
   logic [INNER_W-1:0] inner_cnt;
   logic [OUTER_W-1:0] outer_cnt;
   logic               inner_last;
   logic               outer_last;
   logic               busy;
   logic               done;
   logic               wrap;

   modport master (
      output start, abort, en, cont_mode, inner_limit, outer_limit,
      input  inner_cnt, outer_cnt, inner_last, outer_last, busy, done, wrap
   );

   modport slave (
      input  start, abort, en, cont_mode, inner_limit, outer_limit,
      output inner_cnt, outer_cnt, inner_last, outer_last, busy, done, wrap
   );
endinterface

// File: rtl/counter_loop_nest.sv
// Two-level nested loop counter (inner fastest) with latched terminal values,
// start/busy/done handshake, continuous mode with wrap pulse, stall and abort.
module counter_loop_nest #(
   parameter int INNER_W = 6,
   parameter int OUTER_W = 6
) (
   input logic               clk,
   input logic               rst,
   counter_loop_nest_if.slave bus
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]         state_reg, state_next;
   logic [INNER_W-1:0] inner_reg, inner_next;
   logic [OUTER_W-1:0] outer_reg, outer_next;
   logic [INNER_W-1:0] ilim_reg, ilim_next;
   logic [OUTER_W-1:0] olim_reg, olim_next;
   logic               cont_reg, cont_next;
   logic               done_reg, done_next;
   logic               wrap_reg, wrap_next;

   always_comb begin
      state_next = state_reg;
      inner_next = inner_reg;
      outer_next = outer_reg;
      ilim_next  = ilim_reg;
      olim_next  = olim_reg;
      cont_next  = cont_reg;
      done_next  = 1'b0;
      wrap_next  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            inner_next = '0;
            outer_next = '0;
            // en in the start cycle is deliberately ignored: the run begins at (0,0).
            if (bus.start && !bus.abort) begin
               ilim_next  = bus.inner_limit;
               olim_next  = bus.outer_limit;
               cont_next  = bus.cont_mode;
               state_next = ST_RUN;
            end
         end
         default: begin
            if (bus.abort) begin
               state_next = ST_IDLE;
               inner_next = '0;
               outer_next = '0;
            end else if (bus.en) begin
               if (inner_reg != ilim_reg) begin
                  inner_next = inner_reg + INNER_W'(1);
               end else begin
                  inner_next = '0;
                  if (outer_reg != olim_reg) begin
                     outer_next = outer_reg + OUTER_W'(1);
                  end else begin
                     outer_next = '0;
                     if (cont_reg) begin
                        wrap_next = 1'b1;
                     end else begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                     end
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         inner_reg <= '0;
         outer_reg <= '0;
         ilim_reg  <= '0;
         olim_reg  <= '0;
         cont_reg  <= 1'b0;
         done_reg  <= 1'b0;
         wrap_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         inner_reg <= inner_next;
         outer_reg <= outer_next;
         ilim_reg  <= ilim_next;
         olim_reg  <= olim_next;
         cont_reg  <= cont_next;
         done_reg  <= done_next;
         wrap_reg  <= wrap_next;
      end
   end

   assign bus.inner_cnt  = inner_reg;
   assign bus.outer_cnt  = outer_reg;
   assign bus.busy       = (state_reg == ST_RUN);
   assign bus.inner_last = (state_reg == ST_RUN) && (inner_reg == ilim_reg);
   assign bus.outer_last = (state_reg == ST_RUN) && (outer_reg == olim_reg);
   assign bus.done       = done_reg;
   assign bus.wrap       = wrap_reg;
endmodule

// File: tb/tb_counter_loop_nest.sv
// Directed bench for counter_loop_nest: inputs driven and outputs checked on the
// falling edge. Observed vector = {busy, done, wrap, inner_last, outer_last, inner, outer}.
module tb_counter_loop_nest;
   localparam int IW = 6;
   localparam int OW = 6;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   counter_loop_nest_if #(.INNER_W(IW), .OUTER_W(OW)) bus ();

   counter_loop_nest #(.INNER_W(IW), .OUTER_W(OW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [16:0] obs;
   assign obs = {bus.busy, bus.done, bus.wrap, bus.inner_last, bus.outer_last,
                 bus.inner_cnt, bus.outer_cnt};

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic s, input logic a, input logic e);
      bus.start = s;
      bus.abort = a;
      bus.en    = e;
   endtask

   task automatic test_reset();
      logic [16:0] exp;
      bus.inner_limit = 6'd3;
      bus.outer_limit = 6'd2;
      bus.cont_mode   = 1'b0;
      drive(1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      tick();
      tick();
      exp = 17'h0;
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL reset: got %h expected %h", obs, exp);
      end
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL reset_idle_hold: got %h expected %h", obs, exp);
      end
      $display("test_reset done");
   endtask

   task automatic test_single_shot();
      logic [16:0] exp;
      bus.inner_limit = 6'd3;
      bus.outer_limit = 6'd2;
      bus.cont_mode   = 1'b0;
      drive(1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 12; k++) begin
         exp = {1'b1, 1'b0, 1'b0, (k % 4) == 3, (k / 4) == 2, 6'(k % 4), 6'(k / 4)};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL single_step%0d: got %h expected %h", k, obs, exp);
         end
         tick();
      end
      drive(1'b0, 1'b0, 1'b0);
      exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL single_done: got %h expected %h", obs, exp);
      end
      tick();
      exp = 17'h0;
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL single_done_pulse: got %h expected %h", obs, exp);
      end
      $display("test_single_shot done");
   endtask

   task automatic test_toggle_en();
      logic [16:0] exp;
      int acc;
      acc = 0;
      bus.inner_limit = 6'd3;
      bus.outer_limit = 6'd2;
      bus.cont_mode   = 1'b0;
      drive(1'b1, 1'b0, 1'b0);
      tick();
      for (int c = 0; acc < 12 && c < 40; c++) begin
         drive(1'b0, 1'b0, (c % 2) == 0);
         exp = {1'b1, 1'b0, 1'b0, (acc % 4) == 3, (acc / 4) == 2, 6'(acc % 4), 6'(acc / 4)};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL toggle_c%0d: got %h expected %h", c, obs, exp);
         end
         tick();
         if ((c % 2) == 0) acc++;
      end
      drive(1'b0, 1'b0, 1'b0);
      exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL toggle_done: got %h expected %h", obs, exp);
      end
      tick();
      $display("test_toggle_en done");
   endtask

   task automatic test_continuous();
      logic [16:0] exp;
      bus.inner_limit = 6'd1;
      bus.outer_limit = 6'd1;
      bus.cont_mode   = 1'b1;
      drive(1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1);
      for (int s = 0; s <= 10; s++) begin
         if (s == 10) drive(1'b0, 1'b0, 1'b0);
         exp = {1'b1, 1'b0, (s > 0) && (s % 4) == 0, (s % 2) == 1, ((s / 2) % 2) == 1,
                6'(s % 2), 6'((s / 2) % 2)};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL cont_step%0d: got %h expected %h", s, obs, exp);
         end
         if (s < 10) tick();
      end
      drive(1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0);
      exp = 17'h0;
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL cont_abort: got %h expected %h", obs, exp);
      end
      $display("test_continuous done");
   endtask

   task automatic test_abort();
      logic [16:0] exp;
      bus.inner_limit = 6'd3;
      bus.outer_limit = 6'd2;
      bus.cont_mode   = 1'b0;
      drive(1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1);
      for (int s = 0; s < 6; s++) tick();
      drive(1'b0, 1'b1, 1'b1);
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2, 6'd1};
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL abort_pre: got %h expected %h", obs, exp);
      end
      tick();
      drive(1'b1, 1'b1, 1'b0);
      exp = 17'h0;
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL abort_idle: got %h expected %h", obs, exp);
      end
      tick();
      drive(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL abort_blocks_start: got %h expected %h", obs, exp);
      end
      $display("test_abort done");
   endtask

   task automatic test_back_to_back();
      logic [16:0] exp;
      bus.inner_limit = 6'd0;
      bus.outer_limit = 6'd0;
      bus.cont_mode   = 1'b0;
      drive(1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b1);
      exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 6'd0};
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL zero_run: got %h expected %h", obs, exp);
      end
      tick();
      drive(1'b1, 1'b0, 1'b0);
      exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL zero_done: got %h expected %h", obs, exp);
      end
      tick();
      drive(1'b0, 1'b0, 1'b1);
      exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 6'd0};
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL b2b_restart: got %h expected %h", obs, exp);
      end
      tick();
      drive(1'b0, 1'b0, 1'b0);
      exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL b2b_done: got %h expected %h", obs, exp);
      end
      tick();
      $display("test_back_to_back done");
   endtask

   task automatic test_latched_limit();
      logic [16:0] exp;
      bus.inner_limit = 6'd5;
      bus.outer_limit = 6'd0;
      bus.cont_mode   = 1'b0;
      drive(1'b1, 1'b0, 1'b0);
      tick();
      bus.inner_limit = 6'd2;
      bus.outer_limit = 6'd3;
      bus.cont_mode   = 1'b1;
      drive(1'b1, 1'b0, 1'b1);
      for (int s = 0; s < 6; s++) begin
         exp = {1'b1, 1'b0, 1'b0, s == 5, 1'b1, 6'(s), 6'd0};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL latch_step%0d: got %h expected %h", s, obs, exp);
         end
         tick();
      end
      drive(1'b0, 1'b0, 1'b0);
      exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL latch_done: got %h expected %h", obs, exp);
      end
      tick();
      $display("test_latched_limit done");
   endtask

   task automatic test_rst_mid_run();
      logic [16:0] exp;
      bus.inner_limit = 6'd3;
      bus.outer_limit = 6'd2;
      bus.cont_mode   = 1'b0;
      drive(1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1);
      for (int s = 0; s < 6; s++) tick();
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2, 6'd1};
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL rst_pre: got %h expected %h", obs, exp);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      exp = 17'h0;
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL rst_mid: got %h expected %h", obs, exp);
      end
      bus.inner_limit = 6'd1;
      bus.outer_limit = 6'd0;
      drive(1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1);
      for (int s = 0; s < 2; s++) begin
         exp = {1'b1, 1'b0, 1'b0, s == 1, 1'b1, 6'(s), 6'd0};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL rst_rerun%0d: got %h expected %h", s, obs, exp);
         end
         tick();
      end
      drive(1'b0, 1'b0, 1'b0);
      exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL rst_rerun_done: got %h expected %h", obs, exp);
      end
      tick();
      $display("test_rst_mid_run done");
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      bus.cont_mode   = 1'b0;
      bus.inner_limit = '0;
      bus.outer_limit = '0;
      @(negedge clk);
      test_reset();
      test_single_shot();
      test_toggle_en();
      test_continuous();
      test_abort();
      test_back_to_back();
      test_latched_limit();
      test_rst_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/counter_loop_nest.md
Name: counter_loop_nest

Overview:
- Two-level nested loop counter (inner/outer) with runtime-programmable terminal values.
- Adds a start/busy/done handshake, single-shot or continuous mode, stall via enable, and synchronous abort.
- Sequences index pairs (e.g. coefficient index x frame index) for the cepstral/DCT datapath.
- Successor to the single-level loop counter; the controller FSM drives start/en and consumes inner_last/outer_last/done.

Parameters:
- INNER_W, 6, width of inner counter and inner_limit
- OUTER_W, 6, width of outer counter and outer_limit

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE
- abort  input  1  synchronous cancel of a run
- en  input  1  advance one step when RUN
- cont_mode  input  1  0 = single-shot, 1 = continuous; latched at start
- inner_limit  input  INNER_W  inner terminal value (inclusive); latched at start
- outer_limit  input  OUTER_W  outer terminal value (inclusive); latched at start
- inner_cnt  output  INNER_W  current inner index
- outer_cnt  output  OUTER_W  current outer index
- inner_last  output  1  busy & inner_cnt == latched inner limit
- outer_last  output  1  busy & outer_cnt == latched outer limit
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse on single-shot completion
- wrap  output  1  one-cycle pulse on continuous-mode full-sequence wrap

Behaviour:
- Reset (rst=1 at an edge): state IDLE; inner_cnt=0, outer_cnt=0, busy=0, done=0, wrap=0. Latched limits and mode clear to 0.
- States: IDLE and RUN. done and wrap are registered pulses, not states.
- Priority each cycle: rst > abort > start/en.
- IDLE:
  - Counters held at 0.
  - start=1 and abort=0: latch inner_limit, outer_limit and cont_mode; go to RUN next cycle with counters at 0 and busy=1.
  - start with en in the same cycle: the en is not counted.
- RUN with en=0: all state held.
- RUN with en=1:
  - If inner_cnt != ilim: inner_cnt+1.
  - Otherwise inner_cnt=0, and:
    - If outer_cnt != olim: outer_cnt+1.
    - Otherwise this is the final step. Single-shot: go to IDLE, counters 0, done=1 next cycle. Continuous: counters 0, stay in RUN, wrap=1 next cycle.
- Steps per sequence = (ilim+1)*(olim+1). Counters never exceed their latched limits, so there is no modular overflow.
- start in RUN is ignored. Input limits/mode changes during RUN have no effect.
- abort in RUN: go to IDLE next cycle; counters 0, busy=0, no done or wrap pulse. abort in IDLE: no effect, and it blocks a same-cycle start.
- Limits of 0:
  - inner limit 0: inner_last is constantly 1 during RUN.
  - Both limits 0: the first en completes the run.
- Maximum limits (all ones): full count range, no wrap before terminal.
- inner_last and outer_last are combinational from registered state; both are 0 in IDLE.
- Cycle after final step:
  - Single-shot: done=1, busy=0. start may be accepted in that same cycle.
  - Continuous: wrap=1, busy=1. An en in that cycle advances normally from (0,0).
- Latency: counter outputs reflect an en on the following edge. No combinational path from en to the counters.

Test Plan:
- Single-shot, ilim=3, olim=2, en held 1 after start → busy for 12 cycles. Sequence (0,0),(1,0)..(3,0),(0,1)..(3,2). done pulses one cycle after the (3,2) step; counters return to 0.
- Same config, en toggled 1/0 each cycle → identical index sequence at half rate; state held on en=0 cycles. done arrives after 12 accepted steps.
- Continuous, ilim=1, olim=1, en=1 for 10 cycles → indices repeat (0,0),(1,0),(0,1),(1,1); wrap pulses after the 4th and 8th steps. busy stays 1 and done never asserts.
- Abort at (2,1) with ilim=3, olim=2 → next cycle IDLE, counters 0, no done. Then start with abort=1 in the same cycle → stays IDLE.
- Both limits 0 → one en gives done next cycle. Change inner_limit mid-run with ilim=5 → latched limit 5 is still used.
- rst asserted mid-run at (2,1) → next cycle all outputs 0, IDLE. A subsequent start behaves as from power-up.
